// File: rtl/sirv_icb1ton_dec_bus_if.sv
// ICB bundle with NP parallel ports packed LSB-first; NP=1 for a single link.
// master drives the command and rsp_ready, slave drives cmd_ready and the response.
interface sirv_icb1ton_dec_bus_if #(
    parameter int NP = 1,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [NP-1:0]      cmd_valid;
    logic [NP-1:0]      cmd_ready;
    logic [NP*AW-1:0]   cmd_addr;
    logic [NP-1:0]      cmd_read;
    logic [NP-1:0]      cmd_lock;
    logic [NP-1:0]      cmd_excl;
    logic [NP*DW-1:0]   cmd_wdata;
    logic [NP*DW/8-1:0] cmd_wmask;
    logic [NP*2-1:0]    cmd_size;
    logic [NP*2-1:0]    cmd_burst;
    logic [NP*2-1:0]    cmd_beat;
    logic [NP-1:0]      rsp_valid;
    logic [NP-1:0]      rsp_ready;
    logic [NP-1:0]      rsp_err;
    logic [NP-1:0]      rsp_excl_ok;
    logic [NP*DW-1:0]   rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_lock, cmd_excl, cmd_wdata,
               cmd_wmask, cmd_size, cmd_burst, cmd_beat, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_excl_ok, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_lock, cmd_excl, cmd_wdata,
               cmd_wmask, cmd_size, cmd_burst, cmd_beat, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_excl_ok, rsp_rdata
    );
endinterface

// File: rtl/sirv_icb1ton_dec_bus.sv
// 1-to-N ICB splitter: priority base/region decode, in-order response steering,
// internal error responder for unmapped addresses with a saturating error counter.
module sirv_icb1ton_dec_bus #(
    parameter int               N           = 3,
    parameter int               AW          = 32,
    parameter int               DW          = 32,
    parameter int               OUTS_NUM    = 2,
    parameter logic [N*AW-1:0]  BASE_ADDRS  = {32'h2000_0000, 32'h1000_0000, 32'h0000_1000},
    parameter logic [N*8-1:0]   REGION_LSBS = {8'd28, 8'd28, 8'd12}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    sirv_icb1ton_dec_bus_if.slave         i_icb,
    sirv_icb1ton_dec_bus_if.master        o_icb,
    output logic                          bus_busy,
    output logic [7:0]                    dec_err_cnt
);

    logic [N-1:0]  hit;
    logic [N:0]    tgt;
    logic [N:0]    cur_ptr;
    logic [N:0]    rsel;
    logic [3:0]    outs_cnt;
    logic          outs_zero;
    logic          allow;
    logic          sel_rdy;
    logic          cmd_hs;
    logic          rsp_hs;
    logic          rsp_open;
    logic          err_rsp_valid;
    logic          mux_valid;
    logic          mux_err;
    logic          mux_excl;
    logic [DW-1:0] mux_rdata;

    for (genvar k = 0; k < N; k++) begin : g_hit
        localparam int LSB = int'(REGION_LSBS[k*8 +: 8]);
        assign hit[k] = (i_icb.cmd_addr[AW-1:LSB] == BASE_ADDRS[k*AW+LSB +: AW-LSB]);
    end

    // Scanning downward leaves the lowest hitting port as the winner.
    always_comb begin
        tgt    = '0;
        tgt[N] = 1'b1;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                tgt    = '0;
                tgt[k] = 1'b1;
            end
        end
    end

    assign outs_zero = (outs_cnt == 4'd0);
    assign allow     = outs_zero | ((tgt == cur_ptr) & (outs_cnt < 4'(OUTS_NUM)));
    assign sel_rdy   = tgt[N] | (|(tgt[N-1:0] & o_icb.cmd_ready));

    assign i_icb.cmd_ready = allow & sel_rdy;
    assign cmd_hs          = i_icb.cmd_valid[0] & i_icb.cmd_ready[0];

    assign o_icb.cmd_valid = {N{i_icb.cmd_valid[0] & allow}} & tgt[N-1:0];
    assign o_icb.cmd_addr  = {N{i_icb.cmd_addr}};
    assign o_icb.cmd_read  = {N{i_icb.cmd_read}};
    assign o_icb.cmd_lock  = {N{i_icb.cmd_lock}};
    assign o_icb.cmd_excl  = {N{i_icb.cmd_excl}};
    assign o_icb.cmd_wdata = {N{i_icb.cmd_wdata}};
    assign o_icb.cmd_wmask = {N{i_icb.cmd_wmask}};
    assign o_icb.cmd_size  = {N{i_icb.cmd_size}};
    assign o_icb.cmd_burst = {N{i_icb.cmd_burst}};
    assign o_icb.cmd_beat  = {N{i_icb.cmd_beat}};

    // With nothing outstanding the response path is only open for a same-cycle
    // (0-cycle) responder to the command being accepted right now.
    assign rsel          = outs_zero ? tgt : cur_ptr;
    assign rsp_open      = ~outs_zero | cmd_hs;
    assign err_rsp_valid = cur_ptr[N] & ~outs_zero;

    always_comb begin
        mux_valid = rsel[N] & err_rsp_valid;
        mux_err   = rsel[N];
        mux_excl  = 1'b0;
        mux_rdata = '0;
        for (int k = 0; k < N; k++) begin
            if (rsel[k]) begin
                mux_valid = o_icb.rsp_valid[k];
                mux_err   = o_icb.rsp_err[k];
                mux_excl  = o_icb.rsp_excl_ok[k];
                mux_rdata = o_icb.rsp_rdata[k*DW +: DW];
            end
        end
    end

    assign i_icb.rsp_valid   = mux_valid & rsp_open;
    assign i_icb.rsp_err     = mux_err;
    assign i_icb.rsp_excl_ok = mux_excl;
    assign i_icb.rsp_rdata   = mux_rdata;
    assign o_icb.rsp_ready   = {N{i_icb.rsp_ready[0] & rsp_open}} & rsel[N-1:0];

    assign rsp_hs   = i_icb.rsp_valid[0] & i_icb.rsp_ready[0];
    assign bus_busy = ~outs_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outs_cnt    <= 4'd0;
            cur_ptr     <= '0;
            dec_err_cnt <= 8'd0;
        end else begin
            case ({cmd_hs, rsp_hs})
                2'b10:   outs_cnt <= outs_cnt + 4'd1;
                2'b01:   outs_cnt <= outs_cnt - 4'd1;
                default: outs_cnt <= outs_cnt;
            endcase
            if (cmd_hs) begin
                cur_ptr <= tgt;
                if (tgt[N] && (dec_err_cnt != 8'hff)) begin
                    dec_err_cnt <= dec_err_cnt + 8'd1;
                end
            end
        end
    end

endmodule
